// File: rtl/rs_syndrome_calc_pkg.sv
// Shared GF(2^M) helpers and output FSM state type for the RS syndrome generator.
// All functions are meant for elaboration-time constant evaluation only.
package rs_pkg;

  typedef enum logic {ST_IDLE, ST_SEND} out_state_t;

  // Shift-and-add product reduced by the field polynomial.
  function automatic int gf_mul(input int a, input int b, input int m, input int prim_poly);
    int r;
    int x;
    r = 0;
    x = a;
    for (int k = 0; k < m; k++) begin
      if (((b >> k) & 1) != 0) r = r ^ x;
      x = x << 1;
      if (((x >> m) & 1) != 0) x = x ^ prim_poly;
    end
    return r;
  endfunction

  function automatic int gf_alpha_pow(input int e, input int m, input int prim_poly);
    int r;
    int n;
    r = 1;
    n = e % ((1 << m) - 1);
    for (int k = 0; k < n; k++) r = gf_mul(r, 2, m, prim_poly);
    return r;
  endfunction

endpackage

// File: rtl/rs_gf_const_mul.sv
// Multiply by a fixed GF(2^M) constant: each input bit selects one precomputed
// column of the constant's multiplication matrix, and the columns are XORed.
module rs_gf_const_mul
  import rs_pkg::*;
#(
  parameter int M         = 8,
  parameter int PRIM_POLY = 'h11D,
  parameter int CONST     = 2
) (
  input  logic [M-1:0] din,
  output logic [M-1:0] dout
);

  logic [M-1:0] term [M];

  for (genvar k = 0; k < M; k++) begin : g_col
    localparam int COL = gf_mul(CONST, 1 << k, M, PRIM_POLY);
    assign term[k] = {M{din[k]}} & M'(COL);
  end

  always_comb begin
    dout = '0;
    for (int k = 0; k < M; k++) dout = dout ^ term[k];
  end

endmodule

// File: rtl/rs_syndrome_calc.sv
// Parallel Horner-rule RS syndrome generator with a double-buffered output bank.
// Optional macro RS_SYND_ZERO_SKIP_EN: an all-zero bank is sent as one short beat.
module rs_syndrome_calc
  import rs_pkg::*;
#(
  parameter int M         = 8,
  parameter int N         = 255,
  parameter int NSYM      = 32,
  parameter int FCR       = 1,
  parameter int PRIM_POLY = 'h11D,
  parameter int IDXW      = 6
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            in_sop,
  input  logic [M-1:0]    in_data,
  output logic            syn_valid,
  input  logic            syn_ready,
  output logic [M-1:0]    syn_data,
  output logic [IDXW-1:0] syn_index,
  output logic            syn_last,
  output logic            syn_nonzero,
  output logic            frame_err
);

  localparam int CNTW = $clog2(N + 1);
  localparam int NSW  = $clog2(NSYM);
  localparam logic [CNTW-1:0] CNT_LAST = CNTW'(N - 1);
  localparam logic [IDXW-1:0] IDX_LAST = IDXW'(NSYM - 1);

  logic [1:0]      rst_sync;
  logic            rst_n;
  logic [M-1:0]    acc      [NSYM];
  logic [M-1:0]    acc_mul  [NSYM];
  logic [M-1:0]    acc_next [NSYM];
  logic [M-1:0]    bank     [NSYM];
  logic [CNTW-1:0] sym_cnt;
  logic            bank_full;
  logic            bank_nonzero;
  logic            any_nz;
  logic [IDXW-1:0] idx;
  logic            skip;
  out_state_t      state, state_next;
  logic            accept, take, complete, beat, last_beat;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) rst_sync <= 2'b00;
    else        rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_n = rst_sync[1];

  for (genvar i = 0; i < NSYM; i++) begin : g_mul
    rs_gf_const_mul #(
      .M        (M),
      .PRIM_POLY(PRIM_POLY),
      .CONST    (gf_alpha_pow(FCR + i, M, PRIM_POLY))
    ) u_mul (
      .din (acc[i]),
      .dout(acc_mul[i])
    );
  end

  // Non-sop symbols while waiting for a codeword start are swallowed, not stored.
  assign accept    = in_valid && in_ready;
  assign take      = accept && (in_sop || sym_cnt != '0);
  assign complete  = take && !in_sop && sym_cnt == CNT_LAST;
  assign beat      = syn_valid && syn_ready;
  assign last_beat = beat && syn_last;
  assign in_ready  = !(sym_cnt == CNT_LAST && bank_full && !last_beat);

  always_comb begin
    any_nz = 1'b0;
    for (int i = 0; i < NSYM; i++) begin
      acc_next[i] = in_sop ? in_data : (acc_mul[i] ^ in_data);
      any_nz      = any_nz | (|acc_next[i]);
    end
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NSYM; i++) acc[i] <= '0;
      sym_cnt   <= '0;
      frame_err <= 1'b0;
    end else begin
      frame_err <= accept && in_sop && sym_cnt != '0;
      if (take) begin
        for (int i = 0; i < NSYM; i++) acc[i] <= acc_next[i];
        if (complete)    sym_cnt <= '0;
        else if (in_sop) sym_cnt <= CNTW'(1);
        else             sym_cnt <= sym_cnt + CNTW'(1);
      end
    end
  end

  // A completing load takes priority over the bank release on the final beat.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NSYM; i++) bank[i] <= '0;
      bank_full    <= 1'b0;
      bank_nonzero <= 1'b0;
      idx          <= '0;
    end else begin
      if (complete) begin
        for (int i = 0; i < NSYM; i++) bank[i] <= acc_next[i];
        bank_nonzero <= any_nz;
        bank_full    <= 1'b1;
      end else if (last_beat) begin
        bank_full <= 1'b0;
      end
      if (last_beat) idx <= '0;
      else if (beat) idx <= idx + IDXW'(1);
    end
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (bank_full) state_next = ST_SEND;
      ST_SEND: if (last_beat && !complete) state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

`ifdef RS_SYND_ZERO_SKIP_EN
  assign skip = !bank_nonzero;
`else
  assign skip = 1'b0;
`endif

  always_comb begin
    syn_valid   = (state == ST_SEND);
    syn_data    = (syn_valid && !skip) ? bank[idx[NSW-1:0]] : '0;
    syn_index   = syn_valid ? idx : '0;
    syn_last    = syn_valid && (skip || idx == IDX_LAST);
    syn_nonzero = bank_nonzero;
  end

endmodule

// File: tb/tb_rs_syndrome_calc.sv
// Directed bench for rs_syndrome_calc (default RS(255,223) configuration).
// Expected syndromes come from a direct-sum evaluation S_i = sum r_j * alpha^((1+i)(N-1-j)).
module tb_rs_syndrome_calc;

  localparam int M    = 8;
  localparam int N    = 255;
  localparam int NSYM = 32;
  localparam int IDXW = 6;
  localparam int TMO  = 1000;

  logic            clock = 1'b0;
  logic            reset = 1'b0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic            in_sop = 1'b0;
  logic [M-1:0]    in_data = '0;
  logic            syn_valid;
  logic            syn_ready = 1'b0;
  logic [M-1:0]    syn_data;
  logic [IDXW-1:0] syn_index;
  logic            syn_last;
  logic            syn_nonzero;
  logic            frame_err;

  int checks = 0;
  int failures = 0;

  logic [7:0] cw       [N];
  logic [7:0] exp_syn  [NSYM];
  logic [7:0] exp_save [NSYM];
  logic       exp_nz;
  int         alog     [255];

  always #5 clock = ~clock;

  rs_syndrome_calc #(
    .M(M), .N(N), .NSYM(NSYM), .FCR(1), .PRIM_POLY('h11D), .IDXW(IDXW)
  ) dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_sop(in_sop), .in_data(in_data),
    .syn_valid(syn_valid), .syn_ready(syn_ready), .syn_data(syn_data),
    .syn_index(syn_index), .syn_last(syn_last), .syn_nonzero(syn_nonzero),
    .frame_err(frame_err)
  );

  function automatic int tb_mul(input int a, input int b);
    int r;
    int x;
    int y;
    r = 0;
    x = a;
    y = b;
    while (y != 0) begin
      if ((y & 1) != 0) r = r ^ x;
      x = x << 1;
      if ((x & 'h100) != 0) x = x ^ 'h11D;
      y = y >> 1;
    end
    return r;
  endfunction

  task automatic compute_expected();
    int s;
    exp_nz = 1'b0;
    for (int i = 0; i < NSYM; i++) begin
      s = 0;
      for (int j = 0; j < N; j++)
        if (cw[j] != 8'h00) s = s ^ tb_mul(int'(cw[j]), alog[((1 + i) * (N - 1 - j)) % 255]);
      exp_syn[i] = 8'(s);
      if (s != 0) exp_nz = 1'b1;
    end
  endtask

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic apply_stimulus(input logic [7:0] d, input logic sop);
    int w;
    in_valid = 1'b1;
    in_sop   = sop;
    in_data  = d;
    w = 0;
    while (!in_ready && w < TMO) begin
      @(negedge clock);
      w++;
    end
    if (w >= TMO) check_output("in_ready_timeout", in_ready, 1);
    @(negedge clock);
  endtask

  task automatic send_codeword(input logic expect_ferr);
    for (int j = 0; j < N; j++) begin
      apply_stimulus(cw[j], j == 0);
      if (j == 0) check_output("frame_err_at_sop", frame_err, expect_ferr);
      if (j == 1) check_output("frame_err_pulse_end", frame_err, 0);
    end
    in_valid = 1'b0;
    in_sop   = 1'b0;
  endtask

  task automatic wait_valid();
    int w;
    w = 0;
    while (!syn_valid && w < TMO) begin
      @(negedge clock);
      w++;
    end
    check_output("syn_valid_seen", syn_valid, 1);
  endtask

  task automatic read_bank();
    syn_ready = 1'b1;
    for (int b = 0; b < NSYM; b++) begin
      wait_valid();
      check_output("beat_index", syn_index, b);
      check_output("beat_data", syn_data, exp_syn[b]);
      check_output("beat_last", syn_last, b == NSYM - 1);
      check_output("beat_nonzero", syn_nonzero, exp_nz);
      @(negedge clock);
    end
    syn_ready = 1'b0;
  endtask

  task automatic fill_pattern(input int mul, input int add);
    for (int j = 0; j < N; j++) cw[j] = 8'((j * mul + add) & 'hFF);
  endtask

  initial begin
    alog[0] = 1;
    for (int k = 1; k < 255; k++) alog[k] = tb_mul(alog[k - 1], 2);

    // Reset values.
    repeat (2) @(negedge clock);
    check_output("rst_in_ready", in_ready, 1);
    check_output("rst_syn_valid", syn_valid, 0);
    check_output("rst_syn_data", syn_data, 0);
    check_output("rst_syn_index", syn_index, 0);
    check_output("rst_syn_last", syn_last, 0);
    check_output("rst_syn_nonzero", syn_nonzero, 0);
    check_output("rst_frame_err", frame_err, 0);
    reset = 1'b1;
    repeat (4) @(negedge clock);

    // Symbols before the first sop are dropped.
    for (int k = 0; k < 5; k++) apply_stimulus(8'h55, 1'b0);
    in_valid = 1'b0;
    repeat (3) @(negedge clock);
    check_output("stray_dropped", syn_valid, 0);

    // All-zero codeword, with first-beat latency.
    for (int j = 0; j < N; j++) cw[j] = 8'h00;
    compute_expected();
    send_codeword(1'b0);
    check_output("latency_not_yet", syn_valid, 0);
    @(negedge clock);
    check_output("latency_valid", syn_valid, 1);
    check_output("latency_index", syn_index, 0);
    read_bank();

    // Last symbol = 1: every syndrome equals 1.
    cw[N - 1] = 8'h01;
    compute_expected();
    send_codeword(1'b0);
    wait_valid();
    check_output("last_one_S0", syn_data, 8'h01);
    read_bank();

    // First symbol = 1: S_0 = alpha^254.
    cw[N - 1] = 8'h00;
    cw[0] = 8'h01;
    compute_expected();
    send_codeword(1'b0);
    wait_valid();
    check_output("first_one_S0", syn_data, 8'h8E);
    read_bank();

    // Back-to-back codewords under output backpressure.
    fill_pattern(7, 3);
    compute_expected();
    for (int i = 0; i < NSYM; i++) exp_save[i] = exp_syn[i];
    send_codeword(1'b0);
    fill_pattern(13, 91);
    compute_expected();
    for (int j = 0; j < N - 1; j++) apply_stimulus(cw[j], j == 0);
    in_valid = 1'b1;
    in_sop   = 1'b0;
    in_data  = cw[N - 1];
    check_output("stall_at_254", in_ready, 0);
    repeat (3) @(negedge clock);
    check_output("stall_held", in_ready, 0);
    check_output("hold_valid", syn_valid, 1);
    check_output("hold_index", syn_index, 0);
    check_output("hold_data", syn_data, exp_save[0]);
    syn_ready = 1'b1;
    for (int b = 0; b < NSYM; b++) begin
      check_output("drain_valid", syn_valid, 1);
      check_output("drain_index", syn_index, b);
      check_output("drain_data", syn_data, exp_save[b]);
      check_output("drain_in_ready", in_ready, b == NSYM - 1);
      @(negedge clock);
    end
    in_valid  = 1'b0;
    syn_ready = 1'b0;
    check_output("no_idle_valid", syn_valid, 1);
    check_output("no_idle_index", syn_index, 0);
    read_bank();

    // Mid-frame sop at symbol 100 restarts the codeword.
    fill_pattern(5, 200);
    for (int j = 0; j < 100; j++) apply_stimulus(cw[j], j == 0);
    fill_pattern(29, 17);
    compute_expected();
    send_codeword(1'b1);
    read_bank();

    // Reset at symbol 128 discards the partial codeword.
    fill_pattern(3, 1);
    for (int j = 0; j < 128; j++) apply_stimulus(cw[j], j == 0);
    in_valid = 1'b0;
    reset = 1'b0;
    #1;
    check_output("midcw_rst_in_ready", in_ready, 1);
    check_output("midcw_rst_syn_valid", syn_valid, 0);
    check_output("midcw_rst_frame_err", frame_err, 0);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;
    repeat (4) @(negedge clock);
    for (int k = 0; k < N - 128; k++) apply_stimulus(8'h33, 1'b0);
    in_valid = 1'b0;
    repeat (5) @(negedge clock);
    check_output("partial_discarded", syn_valid, 0);
    fill_pattern(11, 77);
    compute_expected();
    send_codeword(1'b0);
    read_bank();

    // Reset during readout at index 10 discards the undelivered bank.
    fill_pattern(17, 5);
    compute_expected();
    send_codeword(1'b0);
    wait_valid();
    syn_ready = 1'b1;
    repeat (10) @(negedge clock);
    check_output("readout_index_10", syn_index, 10);
    check_output("readout_data_10", syn_data, exp_syn[10]);
    syn_ready = 1'b0;
    reset = 1'b0;
    #1;
    check_output("rd_rst_syn_valid", syn_valid, 0);
    check_output("rd_rst_syn_data", syn_data, 0);
    check_output("rd_rst_syn_index", syn_index, 0);
    check_output("rd_rst_syn_last", syn_last, 0);
    check_output("rd_rst_syn_nonzero", syn_nonzero, 0);
    @(negedge clock);
    reset = 1'b1;
    repeat (6) @(negedge clock);
    check_output("bank_discarded", syn_valid, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
